// File: rtl/sram22_bist_pkg.sv
`timescale 1ns/1ps
// Shared types for the sram22 BIST wrapper: run-control state encoding.
package sram22_bist_pkg;

   typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, DONE} bist_state_t;

endpackage

// File: rtl/det_patgen_if.sv
`timescale 1ns/1ps
// Link between the deterministic pattern generator (master) and its consumer (slave).
interface det_patgen_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int MASK_WIDTH = 4
);
   logic                  en;
   logic                  rst;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] data;
   logic [DATA_WIDTH-1:0] check;
   logic [MASK_WIDTH-1:0] wmask;
   logic                  we;
   logic                  re;
   logic                  done;

   modport master (input en, rst, output addr, data, check, wmask, we, re, done);
   modport slave  (output en, rst, input addr, data, check, wmask, we, re, done);
endinterface

// File: rtl/det_read_tracker.sv
`timescale 1ns/1ps
// Valid-tagged shift pipe carrying {check, addr} of issued reads until the SRAM
// returns their data DEPTH cycles later.
module det_read_tracker #(
   parameter int DEPTH      = 1,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
)(
   input  logic                  clk,
   input  logic                  flush,
   input  logic                  advance,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_check,
   input  logic [ADDR_WIDTH-1:0] push_addr,
   output logic                  out_vld,
   output logic [DATA_WIDTH-1:0] out_check,
   output logic [ADDR_WIDTH-1:0] out_addr
);
   logic [DEPTH-1:0]      vld_p;
   logic [DATA_WIDTH-1:0] chk_p [DEPTH];
   logic [ADDR_WIDTH-1:0] adr_p [DEPTH];

   always_ff @(posedge clk) begin
      if (flush) begin
         vld_p <= '0;
      end else if (advance) begin
         vld_p[0] <= push;
         for (int i = 1; i < DEPTH; i++) vld_p[i] <= vld_p[i-1];
      end
   end

   // Payload needs no reset: it is only looked at when its valid tag is set.
   always_ff @(posedge clk) begin
      if (advance) begin
         chk_p[0] <= push_check;
         adr_p[0] <= push_addr;
         for (int i = 1; i < DEPTH; i++) begin
            chk_p[i] <= chk_p[i-1];
            adr_p[i] <= adr_p[i-1];
         end
      end
   end

   assign out_vld   = vld_p[DEPTH-1];
   assign out_check = chk_p[DEPTH-1];
   assign out_addr  = adr_p[DEPTH-1];
endmodule

// File: rtl/det_patgen_checker.sv
`timescale 1ns/1ps
// BIST consumer: runs the pattern generator, forwards its ops to the SRAM and
// compares returned read data against the generator's check word.
module det_patgen_checker
   import sram22_bist_pkg::*;
#(
   parameter int MAX_ADDR      = 256,
   parameter int ADDR_WIDTH    = $clog2(MAX_ADDR),
   parameter int DATA_WIDTH    = 32,
   parameter int MASK_WIDTH    = 4,
   parameter int READ_LATENCY  = 1,
   parameter int ERR_CNT_WIDTH = 16
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   det_patgen_if.slave              pg,
   output logic [ADDR_WIDTH-1:0]    sram_addr,
   output logic [DATA_WIDTH-1:0]    sram_din,
   output logic [MASK_WIDTH-1:0]    sram_wmask,
   output logic                     sram_we,
   output logic                     sram_re,
   input  logic [DATA_WIDTH-1:0]    sram_dout,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [ERR_CNT_WIDTH-1:0] err_count,
   output logic                     first_err_valid,
   output logic [ADDR_WIDTH-1:0]    first_err_addr,
   output logic [DATA_WIDTH-1:0]    first_err_data,
   output logic                     proto_err
);
   localparam logic [2:0] DRAIN_LAST = 3'(READ_LATENCY - 1);

   function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   bist_state_t           state;
   logic [2:0]            drain_cnt;
   logic                  issue;
   logic                  conflict;
   logic                  trk_vld;
   logic [DATA_WIDTH-1:0] trk_check;
   logic [ADDR_WIDTH-1:0] trk_addr;
   logic                  mismatch;

   // An op presented together with pg.done belongs to no run and is dropped.
   assign issue    = (state == RUN) && !pg.done;
   assign conflict = issue && pg.re && pg.we;

   assign sram_addr  = pg.addr;
   assign sram_din   = pg.data;
   assign sram_wmask = pg.wmask;
   assign sram_we    = issue && pg.we && !pg.re;
   assign sram_re    = issue && pg.re && !pg.we;

   assign pg.en  = issue;
   assign pg.rst = (state == IDLE) || (state == INIT);

   det_read_tracker #(
      .DEPTH      (READ_LATENCY),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_tracker (
      .clk        (clk),
      .flush      (rst || (state == INIT)),
      .advance    ((state == RUN) || (state == DRAIN)),
      .push       (sram_re),
      .push_check (pg.check),
      .push_addr  (pg.addr),
      .out_vld    (trk_vld),
      .out_check  (trk_check),
      .out_addr   (trk_addr)
   );

   assign mismatch = trk_vld && (sram_dout != trk_check);

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         drain_cnt       <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         pass            <= 1'b0;
         err_count       <= '0;
         first_err_valid <= 1'b0;
         first_err_addr  <= '0;
         first_err_data  <= '0;
         proto_err       <= 1'b0;
      end else begin
         if (mismatch) begin
            err_count <= sat_inc(err_count);
            if (!first_err_valid) begin
               first_err_valid <= 1'b1;
               first_err_addr  <= trk_addr;
               first_err_data  <= sram_dout;
            end
         end
         // INIT clearing is placed after the compare update so it always wins.
         case (state)
            IDLE: begin
               if (start) begin
                  state <= INIT;
                  busy  <= 1'b1;
               end
            end
            INIT: begin
               err_count       <= '0;
               first_err_valid <= 1'b0;
               first_err_addr  <= '0;
               first_err_data  <= '0;
               proto_err       <= 1'b0;
               pass            <= 1'b0;
               state           <= RUN;
            end
            RUN: begin
               if (conflict) proto_err <= 1'b1;
               if (pg.done) begin
                  state     <= DRAIN;
                  drain_cnt <= '0;
               end
            end
            DRAIN: begin
               if (drain_cnt == DRAIN_LAST) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_count == '0) && !mismatch && !proto_err;
               end else begin
                  drain_cnt <= drain_cnt + 3'd1;
               end
            end
            DONE: begin
               if (start) begin
                  state <= INIT;
                  busy  <= 1'b1;
                  done  <= 1'b0;
                  pass  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
